mig_app_fifo: RTL and testbench

// - Single-clock buffer and write engine in the ui_clk domain, between the capture datapath and the
//   MIG 7-series user (app_*) interface.
// - Buffers 64-bit sample words in a FIFO. Drains each word as one MIG write command at a linearly

---
 rtl/mig_app_fifo.sv | 167 ++++++++++++++++
 tb/tb_mig_app_fifo.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_app_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mig_app_fifo
// Description : ui_clk-domain sample FIFO feeding single-beat MIG write
//               commands at a linearly incrementing, lap-tracked address.
//               Optional MIG_APP_FIFO_WRAP_STOP_EN halts on first wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module mig_app_fifo #(
    parameter int ASYNC_FIFO_MAXDATA = 63,
    parameter int FIFO_AW            = 4,
    parameter int ADDR_WIDTH         = 27,
    parameter int ADDR_STEP          = 8
) (
    input  logic                              ui_clk,
    input  logic                              ui_clk_sync_rst,
    input  logic                              init_calib_complete,
    input  logic                              wrenb,
    input  logic [ASYNC_FIFO_MAXDATA:0]       wrdata,
    output logic                              space_avail,
    output logic                              data_avail,
    input  logic                              app_rdy,
    input  logic                              app_wdf_rdy,
    output logic                              app_en,
    output logic [2:0]                        app_cmd,
    output logic [ADDR_WIDTH-1:0]             app_addr,
    output logic [ASYNC_FIFO_MAXDATA:0]       app_wdf_data,
    output logic                              app_wdf_wren,
    output logic                              app_wdf_end,
    output logic [(ASYNC_FIFO_MAXDATA+1)/8-1:0] app_wdf_mask,
    output logic                              wr_lap_flag
);

    localparam int              c_DW    = ASYNC_FIFO_MAXDATA + 1;
    localparam int              c_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]    c_FULL  = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_STEP  = (ADDR_WIDTH + 1)'(ADDR_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_DW-1:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0]      r_wptr;
    logic [FIFO_AW-1:0]      r_rptr;
    logic [FIFO_AW:0]        r_count;
    logic                    r_app_en;
    logic                    r_wdf_wren;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [c_DW-1:0]         r_wdf_data;
    logic                    r_lap;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_cmd_done;
    logic                    w_dat_done;
    logic                    w_run;
    logic [ADDR_WIDTH:0]     w_addr_sum;

    assign space_avail  = (r_count != c_FULL);
    assign data_avail   = (r_count != '0);
    // A push while full is dropped regardless of a same-cycle pop.
    assign w_push       = wrenb & space_avail;
    assign w_pop        = (r_state == ST_POP);
    assign w_cmd_done   = ~r_app_en | app_rdy;
    assign w_dat_done   = ~r_wdf_wren | app_wdf_rdy;
    assign w_addr_sum   = {1'b0, r_addr} + c_STEP;

    assign app_en       = r_app_en;
    assign app_cmd      = 3'b000;
    assign app_addr     = r_addr;
    assign app_wdf_data = r_wdf_data;
    assign app_wdf_wren = r_wdf_wren;
    assign app_wdf_end  = r_wdf_wren;
    assign app_wdf_mask = '0;
    assign wr_lap_flag  = r_lap;

`ifdef MIG_APP_FIFO_WRAP_STOP_EN
    logic r_stopped;
    assign w_run = ~r_stopped;
`else
    assign w_run = 1'b1;
`endif

    always_ff @(posedge ui_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wrdata;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state    <= ST_IDLE;
            r_app_en   <= 1'b0;
            r_wdf_wren <= 1'b0;
            r_addr     <= '0;
            r_wdf_data <= '0;
            r_lap      <= 1'b0;
`ifdef MIG_APP_FIFO_WRAP_STOP_EN
            r_stopped  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init_calib_complete && data_avail && w_run) begin
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    r_wdf_data <= r_mem[r_rptr];
                    r_app_en   <= 1'b1;
                    r_wdf_wren <= 1'b1;
                    r_state    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // Command and data channels handshake independently.
                    if (r_app_en && app_rdy) begin
                        r_app_en <= 1'b0;
                    end
                    if (r_wdf_wren && app_wdf_rdy) begin
                        r_wdf_wren <= 1'b0;
                    end
                    if (w_cmd_done && w_dat_done) begin
                        r_state <= ST_IDLE;
                        if (w_addr_sum[ADDR_WIDTH]) begin
                            r_addr <= '0;
`ifdef MIG_APP_FIFO_WRAP_STOP_EN
                            r_lap     <= 1'b1;
                            r_stopped <= 1'b1;
`else
                            r_lap     <= ~r_lap;
`endif
                        end else begin
                            r_addr <= w_addr_sum[ADDR_WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mig_app_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_app_fifo
// Description : Self-checking bench for mig_app_fifo (narrow address so wraps
//               are reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mig_app_fifo;

    localparam int c_AW        = 8;
    localparam int c_STEP      = 8;
    localparam int c_LAP_WORDS = (1 << c_AW) / c_STEP;
`ifdef MIG_APP_FIFO_WRAP_STOP_EN
    localparam int c_RAND_WORDS = c_LAP_WORDS - 1;
`else
    localparam int c_RAND_WORDS = 100;
`endif

    logic        ui_clk = 1'b0;
    logic        ui_clk_sync_rst;
    logic        init_calib_complete;
    logic        wrenb;
    logic [63:0] wrdata;
    logic        space_avail;
    logic        data_avail;
    logic        app_rdy;
    logic        app_wdf_rdy;
    logic        app_en;
    logic [2:0]  app_cmd;
    logic [c_AW-1:0] app_addr;
    logic [63:0] app_wdf_data;
    logic        app_wdf_wren;
    logic        app_wdf_end;
    logic [7:0]  app_wdf_mask;
    logic        wr_lap_flag;

    mig_app_fifo #(
        .ASYNC_FIFO_MAXDATA (63),
        .FIFO_AW            (4),
        .ADDR_WIDTH         (c_AW),
        .ADDR_STEP          (c_STEP)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .wrenb               (wrenb),
        .wrdata              (wrdata),
        .space_avail         (space_avail),
        .data_avail          (data_avail),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .wr_lap_flag         (wr_lap_flag)
    );

    always #5 ui_clk = ~ui_clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    int n_cmd = 0;
    int n_dat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the n-th accepted word goes to n*STEP modulo the address space.
    function automatic logic [63:0] exp_addr(input int n);
        return 64'((n * c_STEP) % (1 << c_AW));
    endfunction

    always @(negedge ui_clk) begin
        if (!ui_clk_sync_rst) begin
            if (app_en && app_rdy) begin
                chk("cmd_addr", 64'(app_addr), exp_addr(n_cmd));
                chk("cmd_op", 64'(app_cmd), 64'd0);
                n_cmd++;
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (n_dat < exp_q.size()) begin
                    chk("wr_data", app_wdf_data, exp_q[n_dat]);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_write: got %0h expected none", app_wdf_data);
                end
                chk("wdf_end", 64'(app_wdf_end), 64'd1);
                chk("wdf_mask", 64'(app_wdf_mask), 64'd0);
                n_dat++;
            end
        end
    end

    task automatic cyc();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic do_reset();
        ui_clk_sync_rst     = 1'b1;
        wrenb               = 1'b0;
        wrdata              = '0;
        init_calib_complete = 1'b0;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        cyc();
        cyc();
        exp_q.delete();
        n_cmd = 0;
        n_dat = 0;
        ui_clk_sync_rst = 1'b0;
    endtask

    task automatic wait_en(input string name);
        for (int i = 0; i < 20 && !app_en; i++) cyc();
        if (!app_en) chk({name, "_timeout"}, 64'(app_en), 64'd1);
    endtask

    task automatic write_one(input logic [63:0] d, input string name);
        int target;
        target = n_cmd + 1;
        wrenb  = 1'b1;
        wrdata = d;
        exp_q.push_back(d);
        cyc();
        wrenb = 1'b0;
        for (int i = 0; i < 20 && (n_cmd < target || n_dat < target); i++) cyc();
        if (n_cmd < target || n_dat < target) chk({name, "_timeout"}, 64'(n_cmd), 64'(target));
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] d;
        logic        cal;
        logic        sp;
        logic        dav;
        logic        en;
        logic        wren;
        logic [7:0]  addr;
        logic [63:0] wd;
    } vec_t;

    localparam logic [63:0] c_W0 = 64'h1111;
    localparam logic [63:0] c_WA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] c_WB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] c_WC = 64'hCCCC_0000_0000_000C;

    initial begin
        vec_t vecs[$];
        int en_cnt, wren_cnt, mcount, pushed, lap_before;

        // Cycle-exact expectations after each clock edge.
        vecs.push_back('{1'b1, c_W0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  64'd0});
        vecs.push_back('{1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  64'd0});
        vecs.push_back('{1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  64'd0});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  64'd0});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0,  c_W0});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd8,  c_W0});
        vecs.push_back('{1'b1, c_WA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd8,  c_W0});
        vecs.push_back('{1'b1, c_WB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd8,  c_W0});
        vecs.push_back('{1'b1, c_WC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd8,  c_WA});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd16, c_WA});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd16, c_WA});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd16, c_WB});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd24, c_WB});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd24, c_WB});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd24, c_WC});
        vecs.push_back('{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd32, c_WC});

        // Reset state
        do_reset();
        chk("rst_space", 64'(space_avail), 64'd1);
        chk("rst_davail", 64'(data_avail), 64'd0);
        chk("rst_en", 64'(app_en), 64'd0);
        chk("rst_wren", 64'({app_wdf_wren, app_wdf_end}), 64'd0);
        chk("rst_addr", 64'(app_addr), 64'd0);
        chk("rst_wdata", app_wdf_data, 64'd0);
        chk("rst_lap", 64'(wr_lap_flag), 64'd0);

        // Calibration gating, then three back-to-back words
        foreach (vecs[i]) begin
            wrenb               = vecs[i].wr;
            wrdata              = vecs[i].d;
            init_calib_complete = vecs[i].cal;
            if (vecs[i].wr) exp_q.push_back(vecs[i].d);
            cyc();
            chk($sformatf("row%0d_ctl", i),
                64'({space_avail, data_avail, app_en, app_wdf_wren, app_addr}),
                64'({vecs[i].sp, vecs[i].dav, vecs[i].en, vecs[i].wren, vecs[i].addr}));
            chk($sformatf("row%0d_wdata", i), app_wdf_data, vecs[i].wd);
        end
        wrenb = 1'b0;

        // Command channel stalled while data channel accepts immediately
        do_reset();
        init_calib_complete = 1'b1;
        app_rdy             = 1'b0;
        wrenb  = 1'b1;
        wrdata = 64'hD0D0_D0D0;
        exp_q.push_back(wrdata);
        cyc();
        wrenb = 1'b0;
        wait_en("stall");
        en_cnt   = 0;
        wren_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            en_cnt   += int'(app_en);
            wren_cnt += int'(app_wdf_wren);
            cyc();
        end
        app_rdy   = 1'b1;
        en_cnt   += int'(app_en);
        wren_cnt += int'(app_wdf_wren);
        cyc();
        chk("stall_en_cycles", 64'(en_cnt), 64'd6);
        chk("stall_wren_cycles", 64'(wren_cnt), 64'd1);
        chk("stall_en_after", 64'(app_en), 64'd0);
        chk("stall_addr", 64'(app_addr), 64'd8);

        // Overflow: 17 pushes into a stalled engine
        do_reset();
        mcount = 0;
        for (int i = 0; i < 17; i++) begin
            wrenb  = 1'b1;
            wrdata = 64'h100 + 64'(i);
            if (mcount < 16) begin
                exp_q.push_back(wrdata);
                mcount++;
            end
            cyc();
            if (i == 14) chk("ovf_space_15", 64'(space_avail), 64'd1);
            if (i == 15) chk("ovf_space_16", 64'(space_avail), 64'd0);
        end
        wrenb = 1'b0;
        chk("ovf_space_17", 64'(space_avail), 64'd0);
        init_calib_complete = 1'b1;
        for (int i = 0; i < 80; i++) cyc();
        chk("ovf_cmds", 64'(n_cmd), 64'd16);
        chk("ovf_data", 64'(n_dat), 64'd16);
        chk("ovf_empty", 64'(data_avail), 64'd0);

        // Address wrap and lap flag
        do_reset();
        init_calib_complete = 1'b1;
        for (int i = 0; i < c_LAP_WORDS - 1; i++) write_one(64'h2000 + 64'(i), "lap_fill");
        chk("wrap_pre_addr", 64'(app_addr), 64'((1 << c_AW) - c_STEP));
        chk("wrap_pre_lap", 64'(wr_lap_flag), 64'd0);
        write_one(64'h2FFF, "wrap_word");
        chk("wrap_addr", 64'(app_addr), 64'd0);
        chk("wrap_lap", 64'(wr_lap_flag), 64'd1);
`ifdef MIG_APP_FIFO_WRAP_STOP_EN
        wrenb  = 1'b1;
        wrdata = 64'h3333;
        exp_q.push_back(wrdata);
        cyc();
        wrenb = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("stop_no_write", 64'(n_cmd), 64'(c_LAP_WORDS));
        chk("stop_held", 64'(data_avail), 64'd1);
        chk("stop_lap", 64'(wr_lap_flag), 64'd1);
`else
        write_one(64'h3333, "after_wrap");
        chk("after_wrap_addr", 64'(app_addr), 64'(c_STEP));
        chk("after_wrap_lap", 64'(wr_lap_flag), 64'd1);
`endif

        // Reset during ISSUE discards everything
        do_reset();
        init_calib_complete = 1'b1;
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        wrenb = 1'b1;
        wrdata = 64'h4444;
        cyc();
        wrdata = 64'h5555;
        cyc();
        wrenb = 1'b0;
        wait_en("midrst");
        ui_clk_sync_rst = 1'b1;
        cyc();
        chk("midrst_en", 64'(app_en), 64'd0);
        chk("midrst_wren", 64'(app_wdf_wren), 64'd0);
        chk("midrst_davail", 64'(data_avail), 64'd0);
        chk("midrst_addr", 64'(app_addr), 64'd0);
        exp_q.delete();
        n_cmd = 0;
        n_dat = 0;
        ui_clk_sync_rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("midrst_idle", 64'(app_en), 64'd0);

        // Random traffic with random back-pressure on both channels
        do_reset();
        init_calib_complete = 1'b1;
        pushed = 0;
        lap_before = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pushed == c_RAND_WORDS && n_cmd == c_RAND_WORDS && n_dat == c_RAND_WORDS) break;
            app_rdy     = ($urandom_range(3) != 0);
            app_wdf_rdy = ($urandom_range(2) != 0);
            if (pushed < c_RAND_WORDS && (pushed - n_cmd) < 14 && (pushed - n_dat) < 14
                && $urandom_range(1) == 1) begin
                wrenb  = 1'b1;
                wrdata = {$urandom, $urandom};
                exp_q.push_back(wrdata);
                pushed++;
            end else begin
                wrenb = 1'b0;
            end
            cyc();
        end
        wrenb = 1'b0;
        cyc();
        chk("rand_cmds", 64'(n_cmd), 64'(c_RAND_WORDS));
        chk("rand_data", 64'(n_dat), 64'(c_RAND_WORDS));
        chk("rand_addr", 64'(app_addr), exp_addr(c_RAND_WORDS));
        lap_before = (c_RAND_WORDS / c_LAP_WORDS) % 2;
        chk("rand_lap", 64'(wr_lap_flag), 64'(lap_before));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
